matrix_scan_controller: RTL and testbench

Sequences the LED matrix column drive and row data for the display. It generates a one-hot column strobe with a programmable dwell time per column and inter-column blanking to avoid ghosting. Row patterns come from a double-buffered frame store. The host writes the back buffer and requests a swap; the swap takes effect only at a frame boundary, so the display never tears.

---
 rtl/matrix_scan_controller.sv | 130 +++++++++++++
 tb/tb_matrix_scan_controller.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// LED matrix column scanner with dwell/blank timing and a
// double-buffered row store swapped only at frame boundaries.
module matrix_scan_controller #(
  parameter int COLS  = 3,
  parameter int ROWS  = 8,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [ROWS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic [COLS-1:0]         col,
  output logic [ROWS-1:0]         row,
  output logic                    frame_start
);
  localparam int AW = $clog2(COLS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [AW-1:0] ILAST = AW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [AW-1:0] idx;
  logic [AW-1:0] nidx;
  logic [AW-1:0] inext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ncnt;
  logic          fsel;
  logic          nfsel;
  logic          pending;
  logic          boundary;
  logic          swap;
  logic [ROWS-1:0] mem [2][COLS];

  assign inext = (idx == ILAST) ? '0 : idx + 1'b1;

  always_comb begin
    nstate = state;
    nidx   = idx;
    ncnt   = cnt + 1'b1;
    if (!enable) begin
      nstate = S_IDLE;
      nidx   = '0;
      ncnt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          nstate = S_SHOW;
          nidx   = '0;
          ncnt   = '0;
        end
        S_SHOW: begin
          if (cnt == DLAST) begin
            ncnt = '0;
            if (BLANK == 0) nidx = inext;
            else nstate = S_BLANK;
          end
        end
        S_BLANK: begin
          if (cnt == BLAST) begin
            nstate = S_SHOW;
            nidx   = inext;
            ncnt   = '0;
          end
        end
        default: begin
          nstate = S_IDLE;
          nidx   = '0;
          ncnt   = '0;
        end
      endcase
    end
  end

  // A fresh entry into column 0 is the only place the buffers may flip.
  assign boundary = (nstate == S_SHOW) && (ncnt == '0)
                    && (nidx == '0);
  assign swap  = boundary && (pending || swap_req);
  assign nfsel = fsel ^ swap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      fsel        <= 1'b0;
      pending     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      col         <= '0;
      row         <= '0;
      for (int i = 0; i < COLS; i++) begin
        mem[0][i] <= '0;
        mem[1][i] <= '0;
      end
    end else begin
      state       <= nstate;
      idx         <= nidx;
      cnt         <= ncnt;
      fsel        <= nfsel;
      pending     <= boundary ? 1'b0 : (pending | swap_req);
      swap_ack    <= swap;
      frame_start <= boundary;
      if (nstate == S_SHOW) begin
        col <= COLS'(1) << nidx;
        row <= mem[nfsel][nidx];
      end else begin
        col <= '0;
        row <= '0;
      end
      // Back buffer is selected by the pre-swap front select.
      if (wr_en && (32'(wr_col) < COLS))
        mem[~fsel][wr_col] <= wr_data;
    end
  end
endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: two configurations checked
// against a frame-position reference model.
module tb_matrix_scan_controller;
  localparam int COLS = 3;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic wr_en;
  logic swap_req;
  logic [1:0] wr_col;
  logic [3:0] wr_data;
  logic [2:0] col_a, col_b;
  logic [3:0] row_a, row_b;
  logic ack_a, ack_b, fs_a, fs_b;

  int n_chk = 0;
  int n_fail = 0;

  int dw [2] = '{4, 1};
  int bl [2] = '{1, 0};
  int m_t [2];
  bit m_pend [2];
  bit m_fs [2];
  logic [3:0] m_buf [2][2][3];
  logic [2:0] e_col [2];
  logic [3:0] e_row [2];
  logic e_fs [2];
  logic e_ack [2];

  always #5 clock = ~clock;

  matrix_scan_controller #(
    .COLS(3), .ROWS(4), .DWELL(4), .BLANK(1)
  ) u_a (
    .clock(clock), .reset(reset), .enable(enable),
    .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(ack_a),
    .col(col_a), .row(row_a), .frame_start(fs_a)
  );

  matrix_scan_controller #(
    .COLS(3), .ROWS(4), .DWELL(1), .BLANK(0)
  ) u_b (
    .clock(clock), .reset(reset), .enable(enable),
    .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(ack_b),
    .col(col_b), .row(row_b), .frame_start(fs_b)
  );

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_t[m] = -1;
      m_pend[m] = 1'b0;
      m_fs[m] = 1'b0;
      e_col[m] = '0;
      e_row[m] = '0;
      e_fs[m] = 1'b0;
      e_ack[m] = 1'b0;
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < 3; c++)
          m_buf[m][s][c] = '0;
    end
  endtask

  // Position within the frame decides column and show/blank.
  task automatic model_edge();
    int per, pos, c, ph;
    bit bnd, sw, show, wsel;
    if (reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      per = dw[m] + bl[m];
      c = 0;
      bnd = 1'b0;
      show = 1'b0;
      if (!enable) begin
        m_t[m] = -1;
      end else begin
        m_t[m]++;
        pos = m_t[m] % (COLS * per);
        c = pos / per;
        ph = pos % per;
        show = ph < dw[m];
        bnd = pos == 0;
      end
      sw = bnd && (m_pend[m] || swap_req);
      if (bnd) m_pend[m] = 1'b0;
      else if (swap_req) m_pend[m] = 1'b1;
      wsel = !m_fs[m];
      if (sw) m_fs[m] = !m_fs[m];
      e_col[m] = show ? 3'(1 << c) : 3'b0;
      e_row[m] = show ? m_buf[m][m_fs[m]][c] : 4'b0;
      e_fs[m] = bnd;
      e_ack[m] = sw;
      if (wr_en && wr_col < 2'd3)
        m_buf[m][wsel][wr_col] = wr_data;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic load_all(input logic [3:0] v);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_en = 1'b1;
      wr_col = 2'(c);
      wr_data = v;
      step();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    wr_en = 1'b0;
    wr_col = '0;
    wr_data = '0;
    swap_req = 1'b0;
    model_reset();
    repeat (2) step();
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0",
               {col_a, row_a, fs_a, ack_a});
    end
    n_chk++;
    if ({col_b, row_b, fs_b, ack_b} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0",
               {col_b, row_b, fs_b, ack_b});
    end
    reset = 1'b0;
    step();
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a} !== 9'b0) begin
      n_fail++;
      $display("FAIL idle_a: got %h want 0",
               {col_a, row_a, fs_a, ack_a});
    end
  endtask

  task automatic test_basic();
    int second;
    second = -1;
    for (int c = 0; c < 3; c++) begin
      wr_en = 1'b1;
      wr_col = 2'(c);
      wr_data = 4'(1 << c);
      step();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    enable = 1'b1;
    step();
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a} !== {3'b001, 4'h1, 2'b11}) begin
      n_fail++;
      $display("FAIL first_show: got %h want %h",
               {col_a, row_a, fs_a, ack_a},
               {3'b001, 4'h1, 2'b11});
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      n_chk++;
      if ({col_a, row_a, fs_a, ack_a} !==
          {e_col[0], e_row[0], e_fs[0], e_ack[0]}) begin
        n_fail++;
        $display("FAIL basic_k%0d: got %h want %h", k,
                 {col_a, row_a, fs_a, ack_a},
                 {e_col[0], e_row[0], e_fs[0], e_ack[0]});
      end
      if (fs_a && second < 0) second = k;
    end
    n_chk++;
    if (second !== 15) begin
      n_fail++;
      $display("FAIL period: got %0d want 15", second);
    end
  endtask

  task automatic test_noblank();
    bit found;
    logic [2:0] xc;
    logic xf;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (fs_b) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL nb_wait: got none want frame_start");
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      xc = 3'(1 << (k % 3));
      xf = (k % 3) == 0;
      n_chk++;
      if (col_b !== xc || fs_b !== xf) begin
        n_fail++;
        $display("FAIL nb_rot_k%0d: got %b/%b want %b/%b",
                 k, col_b, fs_b, xc, xf);
      end
      n_chk++;
      if ({col_b, row_b, fs_b, ack_b} !==
          {e_col[1], e_row[1], e_fs[1], e_ack[1]}) begin
        n_fail++;
        $display("FAIL nb_model_k%0d: got %h want %h", k,
                 {col_b, row_b, fs_b, ack_b},
                 {e_col[1], e_row[1], e_fs[1], e_ack[1]});
      end
    end
  endtask

  task automatic test_swap_coalesce();
    bit found;
    bit seen;
    int acks;
    found = 1'b0;
    seen = 1'b0;
    acks = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (fs_a) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL sc_wait: got none want frame_start");
    end
    wr_en = 1'b1;
    wr_col = 2'd1;
    wr_data = 4'hA;
    step();
    wr_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      step();
      if (ack_a) acks++;
    end
    for (int k = 0; k < 30; k++) begin
      step();
      if (ack_a) begin
        acks++;
        seen = 1'b1;
      end
      n_chk++;
      if ({col_a, row_a, fs_a, ack_a} !==
          {e_col[0], e_row[0], e_fs[0], e_ack[0]}) begin
        n_fail++;
        $display("FAIL sc_model_k%0d: got %h want %h", k,
                 {col_a, row_a, fs_a, ack_a},
                 {e_col[0], e_row[0], e_fs[0], e_ack[0]});
      end
      if (col_a == 3'b010) begin
        n_chk++;
        if (row_a !== (seen ? 4'hA : 4'h2)) begin
          n_fail++;
          $display("FAIL sc_col1_k%0d: got %h want %h", k,
                   row_a, seen ? 4'hA : 4'h2);
        end
      end
    end
    n_chk++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL sc_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_badcol();
    bit seen;
    logic [3:0] xr;
    seen = 1'b0;
    wr_en = 1'b1;
    wr_col = 2'd3;
    wr_data = 4'hF;
    step();
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    if (ack_a) seen = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ack_a) seen = 1'b1;
      n_chk++;
      if ({col_a, row_a, fs_a, ack_a} !==
          {e_col[0], e_row[0], e_fs[0], e_ack[0]}) begin
        n_fail++;
        $display("FAIL bc_model_k%0d: got %h want %h", k,
                 {col_a, row_a, fs_a, ack_a},
                 {e_col[0], e_row[0], e_fs[0], e_ack[0]});
      end
      if (seen) begin
        xr = (e_col[0] == 3'b001) ? 4'h1 :
             (e_col[0] == 3'b010) ? 4'h2 :
             (e_col[0] == 3'b100) ? 4'h4 : 4'h0;
        n_chk++;
        if (row_a !== xr) begin
          n_fail++;
          $display("FAIL bc_row_k%0d: got %h want %h",
                   k, row_a, xr);
        end
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bc_ack: got none want swap_ack");
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (col_a == 3'b010) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL ed_wait: got none want col 010");
    end
    enable = 1'b0;
    step();
    n_chk++;
    if ({col_a, row_a} !== 7'b0) begin
      n_fail++;
      $display("FAIL ed_off: got %h want 0", {col_a, row_a});
    end
    step();
    enable = 1'b1;
    step();
    n_chk++;
    if (col_a !== 3'b001 || fs_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ed_resume: got %b/%b want 001/1",
               col_a, fs_a);
    end
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a} !==
        {e_col[0], e_row[0], e_fs[0], e_ack[0]}) begin
      n_fail++;
      $display("FAIL ed_model: got %h want %h",
               {col_a, row_a, fs_a, ack_a},
               {e_col[0], e_row[0], e_fs[0], e_ack[0]});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 40) != 0);
      wr_en = $urandom_range(0, 1) == 1;
      wr_col = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom);
      swap_req = ($urandom_range(0, 7) == 0);
      step();
      n_chk++;
      if ({col_a, row_a, fs_a, ack_a} !==
          {e_col[0], e_row[0], e_fs[0], e_ack[0]}) begin
        n_fail++;
        $display("FAIL rnd_a_k%0d: got %h want %h", k,
                 {col_a, row_a, fs_a, ack_a},
                 {e_col[0], e_row[0], e_fs[0], e_ack[0]});
      end
      n_chk++;
      if ({col_b, row_b, fs_b, ack_b} !==
          {e_col[1], e_row[1], e_fs[1], e_ack[1]}) begin
        n_fail++;
        $display("FAIL rnd_b_k%0d: got %h want %h", k,
                 {col_b, row_b, fs_b, ack_b},
                 {e_col[1], e_row[1], e_fs[1], e_ack[1]});
      end
    end
    wr_en = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    load_all(4'hF);
    enable = 1'b1;
    step();
    n_chk++;
    if ({col_a, row_a} !== {3'b001, 4'hF}) begin
      n_fail++;
      $display("FAIL rm_show: got %h want %h",
               {col_a, row_a}, {3'b001, 4'hF});
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a} !== 9'b0) begin
      n_fail++;
      $display("FAIL rm_async_show: got %h want 0",
               {col_a, row_a, fs_a, ack_a});
    end
    step();
    reset = 1'b0;
    load_all(4'hF);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_t[0] >= 0 && e_col[0] == 3'b0) found = 1'b1;
    end
    n_chk++;
    if (!found || col_a !== 3'b0) begin
      n_fail++;
      $display("FAIL rm_blank_wait: got %b want blank", col_a);
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({col_a, row_a, fs_a, ack_a, col_b, row_b} !== 16'b0) begin
      n_fail++;
      $display("FAIL rm_async_blank: got %h want 0",
               {col_a, row_a, fs_a, ack_a, col_b, row_b});
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      n_chk++;
      if (row_a !== 4'h0 || col_a !== e_col[0]) begin
        n_fail++;
        $display("FAIL rm_cleared_k%0d: got %b/%h want %b/0",
                 k, col_a, row_a, e_col[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noblank();
    test_swap_coalesce();
    test_badcol();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
